// File: rtl/bpsk_symbol_ctrl.sv
// -----------------------------------------------------------------------------
// bpsk_symbol_ctrl
//   Serialises DATA_W-bit words MSB first into BPSK symbols for a downstream
//   sine generator. Each bit drives 'phase' for SPS clocks while 'en' is high.
//   A one-word hold buffer lets a source keep the link busy back-to-back with
//   no gap cycle between words.
//
// Parameters
//   DATA_W  bits per word (1..16)
//   SPS     clocks per symbol, equal to the downstream sine table depth (2..256)
//
// Ports
//   clk        clock, rising edge
//   rstn       asynchronous active-low reset
//   in_data    payload word, sampled only on a transfer edge
//   in_valid   in_data valid
//   in_ready   word accepted when in_valid && in_ready at a rising edge
//   en         symbol enable to the sine generator
//   phase      symbol phase to the sine generator
//   sym_start  one-cycle pulse on the first clock of every symbol
//   done       one-cycle pulse on the final clock of a burst
//
// Build option
//   BPSK_DIFF_ENCODE_EN  when defined, phase = reference XOR bit, where the
//                        reference tracks the last emitted phase and persists
//                        across bursts until reset.
// -----------------------------------------------------------------------------
module bpsk_symbol_ctrl #(
  parameter int DATA_W = 8,
  parameter int SPS    = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              en,
  output logic              phase,
  output logic              sym_start,
  output logic              done
);

  localparam int SAMP_W = $clog2(SPS);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [SAMP_W-1:0] SAMP_MAX = SAMP_W'(SPS - 1);
  localparam logic [BIT_W-1:0]  BIT_MAX  = BIT_W'(DATA_W - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_full;
  logic [BIT_W-1:0]    r_bit_idx;
  logic [SAMP_W-1:0]   r_samp;
  logic                r_phase;
  logic                r_sym_start;

  logic                w_xfer;
  logic                w_sym_end;
  logic                w_last_bit;
  logic                w_burst_end;
  logic                w_load;
  logic [DATA_W-1:0]   w_load_word;
  logic [DATA_W-1:0]   w_shl;
  logic                w_hold_wr;
  logic                w_hold_rd;
  logic                w_nxt_bit;
  logic                w_ref;
  logic                w_done;
  logic                w_en;

  assign in_ready  = ~r_hold_full;
  assign en        = w_en;
  assign phase     = r_phase;
  assign sym_start = r_sym_start;
  assign done      = w_done;

  assign w_xfer      = in_valid & in_ready;
  assign w_sym_end   = (r_state == SEND) && (r_samp == SAMP_MAX);
  assign w_last_bit  = (r_bit_idx == '0);
  assign w_burst_end = w_sym_end & w_last_bit;
  assign w_shl       = r_shift << 1;

  // A new word enters the shift register either straight from the input
  // (IDLE, or burst end with nothing held) or from the hold buffer.
  assign w_load      = ((r_state == IDLE) && w_xfer) ||
                       (w_burst_end && (r_hold_full || in_valid));
  assign w_load_word = ((r_state == SEND) && r_hold_full) ? r_hold : in_data;

  // On a burst-end cycle an arriving word bypasses the hold buffer.
  assign w_hold_wr   = (r_state == SEND) && w_xfer && !w_burst_end;
  assign w_hold_rd   = w_burst_end && r_hold_full;

  assign w_nxt_bit   = w_load ? w_load_word[DATA_W-1] : w_shl[DATA_W-1];

`ifdef BPSK_DIFF_ENCODE_EN
  logic r_ref;
  // While sending, the reference for the next symbol is the phase being
  // emitted now (it is latched into r_ref at the same symbol end).
  assign w_ref = (r_state == SEND) ? r_phase : r_ref;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_ref <= 1'b0;
    else if (w_sym_end) r_ref <= r_phase;
  end
`else
  assign w_ref = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_xfer) w_state_nxt = SEND;
      end
      SEND: begin
        w_en = 1'b1;
        if (w_burst_end && !r_hold_full && !in_valid) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register, counters, phase and symbol-start pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_samp      <= '0;
      r_phase     <= 1'b0;
      r_sym_start <= 1'b0;
    end else begin
      r_sym_start <= 1'b0;
      if (w_load) begin
        r_shift     <= w_load_word;
        r_bit_idx   <= BIT_MAX;
        r_samp      <= '0;
        r_sym_start <= 1'b1;
        r_phase     <= w_nxt_bit ^ w_ref;
      end else if (w_sym_end) begin
        r_samp <= '0;
        if (!w_last_bit) begin
          r_shift     <= w_shl;
          r_bit_idx   <= r_bit_idx - BIT_W'(1);
          r_sym_start <= 1'b1;
          r_phase     <= w_nxt_bit ^ w_ref;
        end
        // final bit with nothing queued: phase keeps its last value in IDLE
      end else if (r_state == SEND) begin
        r_samp <= r_samp + SAMP_W'(1);
      end
    end
  end

  // Hold buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold      <= in_data;
      r_hold_full <= 1'b1;
    end else if (w_hold_rd) begin
      r_hold_full <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bpsk_symbol_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bpsk_symbol_ctrl
//   Directed bench: single words from IDLE via a vector table, then hand
//   sequences for back-to-back words, hold back-pressure, mid-symbol reset and
//   a DATA_W=1 / SPS=2 instance with continuous traffic.
// -----------------------------------------------------------------------------
module tb_bpsk_symbol_ctrl;

  localparam int SPS = 4;
`ifdef BPSK_DIFF_ENCODE_EN
  localparam bit DIFF = 1'b1;
`else
  localparam bit DIFF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready, en, phase, sym_start, done;

  logic [0:0] in_data2;
  logic       in_valid2;
  logic       in_ready2, en2, phase2, sym_start2, done2;

  int n_tests = 0;
  int n_fail  = 0;
  logic mref  = 1'b0;

  always #5 clk = ~clk;

  bpsk_symbol_ctrl #(.DATA_W(8), .SPS(SPS)) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .en(en), .phase(phase), .sym_start(sym_start),
    .done(done)
  );

  bpsk_symbol_ctrl #(.DATA_W(1), .SPS(2)) dut2 (
    .clk(clk), .rstn(rstn), .in_data(in_data2), .in_valid(in_valid2),
    .in_ready(in_ready2), .en(en2), .phase(phase2), .sym_start(sym_start2),
    .done(done2)
  );

  typedef struct {
    logic [7:0] word;
    logic [7:0] exp_phase;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // expected phase bits for n payload bits, advancing the reference model
  function automatic logic [31:0] enc_bits(input logic [31:0] b, input int n);
    logic [31:0] r = '0;
    for (int i = n - 1; i >= 0; i--) begin
      r[i] = DIFF ? (b[i] ^ mref) : b[i];
      mref = r[i];
    end
    return r;
  endfunction

  // Checks a contiguous stream starting on the negedge after the first transfer
  task automatic check_stream(input logic [31:0] exp, input int n);
    for (int k = 0; k < n * SPS; k++) begin
      @(negedge clk);
      chk("en", en, 1);
      chk("phase", phase, exp[n - 1 - k / SPS]);
      chk("sym_start", sym_start, (k % SPS) == 0);
      chk("done", done, k == n * SPS - 1);
    end
    @(negedge clk);
    chk("en_after", en, 0);
    chk("done_after", done, 0);
    chk("sym_start_after", sym_start, 0);
    chk("phase_hold", phase, exp[0]);
    chk("ready_after", in_ready, 1);
  endtask

  // Called at posedge+1 with the DUT idle
  task automatic send1(input logic [7:0] w);
    in_valid = 1'b1;
    in_data  = w;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~w;  // garbage after the transfer must not matter
  endtask

  initial begin
    tbl[0] = '{8'hA5, DIFF ? 8'hC6 : 8'hA5};
    tbl[1] = '{8'hF0, DIFF ? 8'hA0 : 8'hF0};
    tbl[2] = '{8'h01, DIFF ? 8'h01 : 8'h01};
    tbl[3] = '{8'h3C, DIFF ? 8'hD7 : 8'h3C};

    rstn = 1'b0; in_valid = 1'b0; in_data = '0;
    in_valid2 = 1'b0; in_data2 = '0;
    #3;
    chk("rst_en", en, 0);
    chk("rst_phase", phase, 0);
    chk("rst_sym_start", sym_start, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // idle with data wiggling but no valid
    in_data = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_en", en, 0);
    chk("idle_phase", phase, 0);
    chk("idle_ready", in_ready, 1);

    // single words from IDLE
    for (int i = 0; i < 4; i++) begin
      send1(tbl[i].word);
      check_stream({24'h0, tbl[i].exp_phase}, 8);
      mref = tbl[i].exp_phase[0];
      @(posedge clk); #1;
    end

    // 0xFF then 0x00 with in_valid held: second word goes into hold
    begin
      logic [31:0] e;
      e = enc_bits(32'hFF00, 16);
      fork
        begin
          in_valid = 1'b1; in_data = 8'hFF;
          @(posedge clk); #1;
          in_data = 8'h00;
          chk("b2b_ready_empty", in_ready, 1);
          @(posedge clk); #1;
          chk("b2b_ready_full", in_ready, 0);
          in_valid = 1'b0; in_data = 8'h77;
        end
        begin
          @(posedge clk);
          check_stream(e, 16);
        end
      join
    end
    @(posedge clk); #1;

    // back-pressure: third word waits while hold is full
    begin
      logic [31:0] e;
      bit ok;
      e = enc_bits(32'h3CC35A, 24);
      fork
        begin
          in_valid = 1'b1; in_data = 8'h3C;
          @(posedge clk); #1;
          in_data = 8'hC3;
          @(posedge clk); #1;
          in_data = 8'h5A;
          chk("bp_ready_low", in_ready, 0);
          repeat (3) @(posedge clk);
          #1 in_data = 8'hFF;   // altered while not ready
          repeat (3) @(posedge clk);
          #1 in_data = 8'h5A;
          ok = 1'b0;
          for (int c = 0; c < 200; c++) begin
            if (in_ready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
          end
          chk("bp_ready_wait", ok, 1);
          @(posedge clk); #1;
          in_valid = 1'b0; in_data = 8'h00;
        end
        begin
          @(posedge clk);
          check_stream(e, 24);
        end
      join
    end
    @(posedge clk); #1;

    // reset at sample 2 of bit 5
    send1(8'hA5);
    repeat (11) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    chk("mr_en", en, 0);
    chk("mr_phase", phase, 0);
    chk("mr_done", done, 0);
    chk("mr_sym_start", sym_start, 0);
    chk("mr_ready", in_ready, 1);
    @(negedge clk);
    chk("mr_done_held", done, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    mref = 1'b0;
    send1(8'h80);
    check_stream(enc_bits(32'h80, 8), 8);
    @(posedge clk); #1;

    // DATA_W=1, SPS=2, continuous alternating traffic
    begin
      int  cnt;
      bit  r;
      logic ref2;
      logic p;
      ref2 = 1'b0;
      p    = 1'b0;
      fork
        begin
          in_valid2 = 1'b1; in_data2 = 1'b1; cnt = 0;
          for (int c = 0; c < 100 && cnt < 16; c++) begin
            @(negedge clk); r = in_ready2;
            @(posedge clk); #1;
            if (r) begin
              cnt++;
              in_data2 = ~in_data2;
              if (cnt == 16) in_valid2 = 1'b0;
            end
          end
          chk("w1_xfers", cnt, 16);
        end
        begin
          @(posedge clk);
          for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
              p    = DIFF ? (((k / 2) % 2 == 0) ^ ref2) : ((k / 2) % 2 == 0);
              ref2 = p;
            end
            chk("w1_en", en2, 1);
            chk("w1_phase", phase2, p);
            chk("w1_sym_start", sym_start2, (k % 2) == 0);
            chk("w1_done", done2, k == 31);
            if (k < 30) chk("w1_ready", in_ready2, (k % 2) == 0);
          end
          @(negedge clk);
          chk("w1_en_after", en2, 0);
        end
      join
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
